// File: rtl/hash_io_pkg.sv
// hash_io_pkg: shared types and parameter helpers for the hash core host I/O controller.
package hash_io_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_t;

    function automatic int unsigned calc_nw(input int unsigned block_w, input int unsigned bus_w);
        return block_w / bus_w;
    endfunction

    function automatic int unsigned calc_nd(input int unsigned digest_w, input int unsigned bus_w);
        return digest_w / bus_w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int unsigned bus_w, input int unsigned block_w,
                                     input int unsigned digest_w);
        return (bus_w > 0) && (block_w > bus_w) && (digest_w >= bus_w) &&
               (block_w % bus_w == 0) && (digest_w % bus_w == 0);
    endfunction

endpackage

// File: rtl/hash_io_ser.sv
// hash_io_ser: digest capture register and MSB-word-first serialiser toward the host.
module hash_io_ser
    import hash_io_pkg::*;
#(
    parameter int unsigned BUS_W    = 16,
    parameter int unsigned DIGEST_W = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                capture,
    input  logic [DIGEST_W-1:0] hash,
    input  logic                fetch,
    output logic [BUS_W-1:0]    odata,
    output logic                fetch_ack,
    output logic                digest_valid,
    output logic                digest_ovf
);
    localparam int unsigned ND = calc_nd(DIGEST_W, BUS_W);
    localparam int unsigned PW = cnt_w(ND);

    logic [DIGEST_W-1:0] dig_q;
    logic [PW-1:0]       ptr_q;

    // The digest shifts left on each read so the next word is always in the top slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q        <= '0;
            ptr_q        <= '0;
            odata        <= '0;
            fetch_ack    <= 1'b0;
            digest_valid <= 1'b0;
            digest_ovf   <= 1'b0;
        end else begin
            fetch_ack <= 1'b0;
            if (init) begin
                ptr_q        <= '0;
                digest_valid <= 1'b0;
                digest_ovf   <= 1'b0;
            end else if (capture) begin
                dig_q        <= hash;
                ptr_q        <= '0;
                digest_valid <= 1'b1;
                if (digest_valid) begin
                    digest_ovf <= 1'b1;
                end
            end else if (fetch && digest_valid) begin
                odata     <= dig_q[DIGEST_W-1 -: BUS_W];
                dig_q     <= dig_q << BUS_W;
                fetch_ack <= 1'b1;
                if (ptr_q == PW'(ND - 1)) begin
                    ptr_q        <= '0;
                    digest_valid <= 1'b0;
                end else begin
                    ptr_q <= ptr_q + PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/hash_io_ctrl.sv
// hash_io_ctrl: assembles host words into a message block, runs the core, returns the digest.
// Define HASH_IO_DBL_BUF_EN to allow loading the next block while the core is running.
module hash_io_ctrl
    import hash_io_pkg::*;
#(
    parameter int unsigned BUS_W    = 16,
    parameter int unsigned BLOCK_W  = 512,
    parameter int unsigned DIGEST_W = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                load,
    input  logic [BUS_W-1:0]    idata,
    output logic                in_ready,
    output logic                load_ack,
    input  logic                fetch,
    output logic [BUS_W-1:0]    odata,
    output logic                fetch_ack,
    output logic                digest_valid,
    output logic                digest_ovf,
    output logic                start,
    output logic [BLOCK_W-1:0]  msg_block,
    input  logic                busy,
    input  logic [DIGEST_W-1:0] hash
);
    localparam int unsigned NW = calc_nw(BLOCK_W, BUS_W);
    localparam int unsigned CW = cnt_w(NW);

`ifdef HASH_IO_DBL_BUF_EN
    localparam bit DBL_BUF = 1'b1;
`else
    localparam bit DBL_BUF = 1'b0;
`endif

    if (!params_ok(BUS_W, BLOCK_W, DIGEST_W)) begin : g_param_check
        $error("hash_io_ctrl: BUS_W must divide BLOCK_W and DIGEST_W");
    end

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [BLOCK_W-1:0] fill_q;
    logic               busy_q;
    logic               alive_q;
    logic               pending_q;
    logic               accept;
    logic               last_accept;
    logic               busy_fall;
    logic               capture;

    // alive_q keeps in_ready low while in reset and until the first clock after release.
    always_comb begin
`ifdef HASH_IO_DBL_BUF_EN
        in_ready = alive_q && ((state_q == FILL) || !pending_q);
`else
        in_ready = alive_q && (state_q == FILL);
`endif
    end

    always_comb begin
        accept      = load && in_ready && !init;
        last_accept = accept && (cnt_q == CW'(NW - 1));
        busy_fall   = busy_q && !busy;
        capture     = (state_q == RUN) && busy_fall && !init;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (last_accept) state_d = LAUNCH;
            LAUNCH:  state_d = RUN;
            RUN:     if (busy_fall) state_d = (DBL_BUF && (pending_q || last_accept)) ? LAUNCH : FILL;
            default: state_d = FILL;
        endcase
        if (init) begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            fill_q    <= '0;
            busy_q    <= 1'b0;
            alive_q   <= 1'b0;
            pending_q <= 1'b0;
            load_ack  <= 1'b0;
            start     <= 1'b0;
            msg_block <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy;
            alive_q  <= 1'b1;
            load_ack <= accept;
            start    <= 1'b0;
            if (init) begin
                cnt_q     <= '0;
                fill_q    <= '0;
                pending_q <= 1'b0;
            end else begin
                if (accept) begin
                    fill_q <= {fill_q[BLOCK_W-BUS_W-1:0], idata};
                    cnt_q  <= last_accept ? '0 : cnt_q + CW'(1);
                end
                // A block completed outside FILL waits here until the core is free.
                if (last_accept && (state_q != FILL)) begin
                    pending_q <= 1'b1;
                end
                if (state_q == LAUNCH) begin
                    msg_block <= fill_q;
                    start     <= 1'b1;
                    pending_q <= 1'b0;
                end
            end
        end
    end

    hash_io_ser #(
        .BUS_W    (BUS_W),
        .DIGEST_W (DIGEST_W)
    ) u_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .init         (init),
        .capture      (capture),
        .hash         (hash),
        .fetch        (fetch),
        .odata        (odata),
        .fetch_ack    (fetch_ack),
        .digest_valid (digest_valid),
        .digest_ovf   (digest_ovf)
    );

endmodule

// File: tb/tb_hash_io_ctrl.sv
// tb_hash_io_ctrl: directed and randomized bench against a queue-based model of the controller.
module tb_hash_io_ctrl;
    localparam int NW = 32;
    localparam int ND = 16;
`ifdef HASH_IO_DBL_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init = 1'b0;
    logic         load = 1'b0;
    logic [15:0]  idata = '0;
    logic         fetch = 1'b0;
    logic         busy = 1'b0;
    logic [255:0] hash = '0;
    logic         in_ready, load_ack, fetch_ack, digest_valid, digest_ovf, start;
    logic [15:0]  odata;
    logic [511:0] msg_block;

    hash_io_ctrl #(
        .BUS_W    (16),
        .BLOCK_W  (512),
        .DIGEST_W (256)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init         (init),
        .load         (load),
        .idata        (idata),
        .in_ready     (in_ready),
        .load_ack     (load_ack),
        .fetch        (fetch),
        .odata        (odata),
        .fetch_ack    (fetch_ack),
        .digest_valid (digest_valid),
        .digest_ovf   (digest_ovf),
        .start        (start),
        .msg_block    (msg_block),
        .busy         (busy),
        .hash         (hash)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: words held as queues, digest as a queue of unread words.
    logic [15:0]  m_blk[$];
    logic [15:0]  m_full[$];
    logic [15:0]  m_launch_blk[$];
    logic [15:0]  m_dig[$];
    bit           m_has_full, m_launch, m_locked, m_run, m_ovf, m_alive;
    logic         m_bz_prev;
    logic [15:0]  m_odata;
    logic [511:0] m_msg;
    bit           e_load_ack, e_fetch_ack, e_start;

    int           core_len = 10;
    int           core_left = 0;
    bit           core_arm = 1'b0;
    bit           rand_hash = 1'b0;
    logic [255:0] core_hash = '0;

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit exp_rdy();
        return m_alive && ((!m_launch && !m_run) || (DBL && !m_has_full && !m_locked));
    endfunction

    function automatic logic [511:0] pack_block(input logic [15:0] q[$]);
        logic [511:0] v;
        v = '0;
        foreach (q[i]) v[511 - 16*i -: 16] = q[i];
        return v;
    endfunction

    task automatic model_reset();
        m_blk.delete(); m_full.delete(); m_launch_blk.delete(); m_dig.delete();
        m_has_full = 0; m_launch = 0; m_locked = 0; m_run = 0; m_ovf = 0; m_alive = 0;
        m_bz_prev = 0; m_odata = '0; m_msg = '0;
        e_load_ack = 0; e_fetch_ack = 0; e_start = 0;
    endtask

    task automatic model_edge(input bit ld, input logic [15:0] d, input bit ft,
                              input logic bz, input logic [255:0] hs, input bit ini);
        bit rdy;
        bit cap;
        rdy = exp_rdy();
        cap = m_run && m_bz_prev && !bz && !ini;
        e_load_ack = 0; e_fetch_ack = 0; e_start = 0;
        if (ini) begin
            m_blk.delete(); m_dig.delete();
            m_has_full = 0; m_launch = 0; m_locked = 0; m_run = 0; m_ovf = 0;
        end else begin
            if (ld && rdy) begin
                e_load_ack = 1;
                m_blk.push_back(d);
                if (m_blk.size() == NW) begin
                    m_full = m_blk;
                    m_blk.delete();
                    m_has_full = 1;
                end
            end
            if (m_launch) begin
                e_start = 1; m_msg = pack_block(m_launch_blk);
                m_launch = 0; m_locked = 0; m_run = 1;
            end else if (m_run) begin
                if (cap) begin
                    m_run = 0;
                    if (m_dig.size() != 0) m_ovf = 1;
                    m_dig.delete();
                    for (int i = 0; i < ND; i++) m_dig.push_back(hs[255 - 16*i -: 16]);
                    if (m_has_full) begin
                        m_launch_blk = m_full; m_has_full = 0; m_launch = 1; m_locked = 1;
                    end
                end
            end else if (m_has_full) begin
                m_launch_blk = m_full; m_has_full = 0; m_launch = 1; m_locked = 0;
            end
            if (!cap && ft && m_dig.size() != 0) begin
                m_odata = m_dig.pop_front();
                e_fetch_ack = 1;
            end
        end
        m_bz_prev = bz;
        m_alive = 1;
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, exp_rdy());
        chk("load_ack", load_ack, e_load_ack);
        chk("fetch_ack", fetch_ack, e_fetch_ack);
        chk("start", start, e_start);
        chk("digest_valid", digest_valid, m_dig.size() != 0);
        chk("digest_ovf", digest_ovf, m_ovf);
        chk("odata", odata, m_odata);
        chk("msg_block", msg_block, m_msg);
    endtask

    // One clock: check outputs, drive inputs and the core, advance the model; ends on next negedge.
    task automatic step(input bit ld, input logic [15:0] d, input bit ft, input bit ini);
        logic prev;
        check_outputs();
        prev = busy;
        if (!rst_n) begin
            core_arm = 0; core_left = 0; busy = 0; hash = '0;
        end else begin
            if (core_arm) begin
                core_arm = 0;
                core_left = core_len;
                if (rand_hash) core_hash = rnd256();
            end
            if (core_left > 0) begin
                busy = 1; core_left--; hash = rnd256();
            end else begin
                busy = 0; hash = prev ? core_hash : rnd256();
            end
            if (start) core_arm = 1;
        end
        load = ld; idata = d; fetch = ft; init = ini;
        if (!rst_n) model_reset();
        else model_edge(ld, d, ft, busy, hash, ini);
        @(negedge clk);
    endtask

    task automatic load_block(input bit sequential);
        for (int i = 0; i < NW; i++) step(1'b1, sequential ? 16'(i) : 16'($urandom()), 1'b0, 1'b0);
    endtask

    logic [255:0] h2;

    initial begin
        model_reset();
        @(negedge clk);
        repeat (3) step(0, '0, 0, 0);
        rst_n = 1'b1;
        repeat (2) step(0, '0, 0, 0);

        // Sequential block, fixed 10-cycle core, known digest.
        core_len = 10;
        core_hash = 256'h0123456789abcdef_0123456789abcdef_0123456789abcdef_0123456789abcdef;
        load_block(1'b1);
        repeat (16) step(0, '0, 0, 0);
        chk("msg_first_word", msg_block[511:496], 16'h0000);
        chk("msg_last_word", msg_block[15:0], 16'h001f);
        chk("valid_after_run", digest_valid, 1'b1);
        step(0, '0, 1, 0);
        chk("first_fetch_word", odata, 16'h0123);
        repeat (ND - 1) step(0, '0, 1, 0);
        chk("valid_after_last_fetch", digest_valid, 1'b0);

        // Keep loading straight through a run.
        rand_hash = 1'b1;
        repeat (NW + 40) step(1, 16'($urandom()), 0, 0);
        repeat (40) step(0, '0, 0, 0);
        step(0, '0, 0, 1);

        // Two runs without reading: overflow, second digest returned.
        rand_hash = 1'b0;
        core_hash = rnd256();
        load_block(1'b0);
        repeat (16) step(0, '0, 0, 0);
        h2 = rnd256();
        core_hash = h2;
        load_block(1'b0);
        repeat (16) step(0, '0, 0, 0);
        chk("ovf_after_two_runs", digest_ovf, 1'b1);
        step(0, '0, 1, 0);
        chk("second_hash_word0", odata, h2[255:240]);

        // init while the core is running.
        load_block(1'b0);
        repeat (5) step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        repeat (15) step(0, '0, 0, 0);
        chk("valid_after_init", digest_valid, 1'b0);
        chk("ovf_after_init", digest_ovf, 1'b0);

        // Asynchronous reset in the middle of reading a digest.
        core_hash = rnd256();
        load_block(1'b0);
        repeat (16) step(0, '0, 0, 0);
        repeat (5) step(0, '0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_odata", odata, 16'h0000);
        chk("rst_valid", digest_valid, 1'b0);
        chk("rst_msg_block", msg_block, '0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_fetch_ack", fetch_ack, 1'b0);
        model_reset();
        @(negedge clk);
        repeat (2) step(0, '0, 0, 0);
        rst_n = 1'b1;
        step(0, '0, 1, 0);
        chk("fetch_after_reset", fetch_ack, 1'b0);

        // Randomized traffic.
        rand_hash = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            core_len = $urandom_range(1, 12);
            step(($urandom() % 10) < 6, 16'($urandom()), ($urandom() % 10) < 3,
                 ($urandom() % 200) == 0);
        end
        step(0, '0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
